// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit path.
//   tx_state_t      : frame FSM states (3-bit encoding)
//   START/STOP_BIT  : line levels of the framing bits
//   MAX_DATA_WIDTH  : widest payload the 4-bit bit index can address
//   parity_bit()    : parity of a payload, even (typ=0) or odd (typ=1)
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT_LEVEL = 1'b0;
    localparam logic STOP_BIT_LEVEL  = 1'b1;

    localparam int MAX_DATA_WIDTH = 16;

    // Callers zero-extend narrower payloads; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input logic                      typ);
        return (^data) ^ typ;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_timer
// Bit-period timer for the transmitter: edge_cnt counts clock cycles within a
// bit, bit_idx counts completed bits within the current FSM state.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   enable    : count this cycle (a frame is in flight)
//   clear     : restart both counters (FSM changes state on this edge)
//   P         : cycles per bit; 0 and 1 both mean one cycle per bit
//   bit_done  : last cycle of the current bit
//   bit_idx   : number of bits completed in the current state
// -----------------------------------------------------------------------------
module uart_tx_bit_timer #(
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] P,
    output logic                      bit_done,
    output logic [3:0]                bit_idx
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] last_edge;

    // Prescale 0 is folded into 1 so a zero setting cannot stall the line.
    assign last_edge = (P == '0 || P == PRESCALE_WIDTH'(1)) ? '0 : P - PRESCALE_WIDTH'(1);
    assign bit_done  = enable && (edge_cnt == last_edge);

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments in clocked logic so every register
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            edge_cnt <= '0;
            bit_idx  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_idx  <= '0;
        end else if (enable) begin
            if (bit_done) begin
                edge_cnt <= '0;
                bit_idx  <= bit_idx + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: start(0), DATA_WIDTH data bits LSB first, optional parity,
// stop(1); each bit held for `prescale` clock cycles.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   P_DATA      : payload, sampled on the accepting edge
//   DATA_VALID  : request; honoured only while idle
//   PAR_EN      : 1 = insert parity bit
//   PAR_TYP     : 0 = even, 1 = odd parity
//   prescale    : clock cycles per bit, sampled on the accepting edge
//   TX_OUT      : registered serial line, idles high
//   Busy        : registered, high while a frame is in flight
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH - 1);

    tx_state_t                 state, next_state;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q, par_typ_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;

    logic                      accept;
    logic                      bit_done;
    logic [3:0]                bit_idx;
    logic [3:0]                idx_next;
    logic [DATA_WIDTH-1:0]     data_shifted;
    logic                      tx_next;

    assign accept = (state == IDLE) && DATA_VALID;

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (state != IDLE),
        .clear    (next_state != state),
        .P        (prescale_q),
        .bit_done (bit_done),
        .bit_idx  (bit_idx)
    );

    always_comb begin
        // NOTE: default first so every path assigns next_state; without it
        // the unlisted cases would infer a latch.
        next_state = state;
        case (state)
            IDLE:    if (DATA_VALID) next_state = START;
            START:   if (bit_done)   next_state = DATA;
            DATA:    if (bit_done && bit_idx == LAST_IDX)
                         next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_done)   next_state = STOP;
            STOP:    if (bit_done)   next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // TX_OUT is registered, so it is loaded with the level of the state and
    // bit that will be current after this edge.
    always_comb begin
        idx_next = '0;
        if (state == DATA && next_state == DATA)
            idx_next = bit_done ? bit_idx + 4'd1 : bit_idx;
        data_shifted = data_q >> idx_next;
        case (next_state)
            START:   tx_next = START_BIT_LEVEL;
            DATA:    tx_next = data_shifted[0];
            PARITY:  tx_next = parity_bit(MAX_DATA_WIDTH'(data_q), par_typ_q);
            default: tx_next = STOP_BIT_LEVEL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            TX_OUT     <= STOP_BIT_LEVEL;
            Busy       <= 1'b0;
            // NOTE: payload/config latches are reset too, so an aborted frame
            // leaves no stale data or prescale behind.
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= '0;
        end else begin
            state  <= next_state;
            TX_OUT <= tx_next;
            Busy   <= (next_state != IDLE);
            if (accept) begin
                data_q     <= P_DATA;
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                prescale_q <= prescale;
            end
        end
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter that serialises one byte per frame onto TX_OUT. Each bit is held for `prescale` system-clock cycles, which matches the oversampling ratio the receive side uses, so both ends share one prescale register. Frame order is start(0), 8 data bits LSB-first, an optional parity bit, then stop(1). The block sits in the UART TX path and takes parallel data from the system/FIFO side with a valid/busy handshake.

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESCALE_WIDTH, 5, width of prescale input (max 31 cycles/bit)

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel byte to send
DATA_VALID  input  1  request; P_DATA valid this cycle
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even, 1 = odd parity
prescale  input  PRESCALE_WIDTH  clock cycles per bit
TX_OUT  output  1  serial line, registered, idles high
Busy  output  1  high while a frame is in flight, registered

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE, TX_OUT=1, Busy=0, all counters=0, latched data/config=0. Reset has priority over everything. A reset mid-frame aborts the frame and returns TX_OUT to 1 on the next edge.
- Acceptance: a frame is accepted only when state=IDLE and DATA_VALID=1 at a clock edge. On that edge the block latches P_DATA, PAR_EN, PAR_TYP and prescale. DATA_VALID is ignored whenever state≠IDLE; there is no queueing.
- Latency: on the edge that accepts the frame, TX_OUT becomes 0 (start bit) and Busy becomes 1. Both are visible in the cycle after DATA_VALID is sampled.
- Effective prescale P = latched prescale. Values 0 and 1 are treated as 1 (one cycle per bit). Changing the prescale input mid-frame has no effect.
- Bit timer: edge_cnt counts 0..P-1 within a bit. When edge_cnt=P-1, bit_done=1, edge_cnt wraps to 0 and bit_idx increments. bit_idx is 4 bits and resets to 0 at each state change.
- FSM states and transitions:
  - IDLE: accept as above, then go to START.
  - START: TX_OUT=0 for P cycles, then go to DATA.
  - DATA: TX_OUT=data[bit_idx], LSB first, P cycles per bit. After bit DATA_WIDTH-1 completes, go to PARITY if PAR_EN is latched, else to STOP.
  - PARITY: TX_OUT = XOR(data) XOR PAR_TYP for P cycles, then go to STOP. Parity is computed from latched data, never from live P_DATA.
  - STOP: TX_OUT=1 for P cycles, then go to IDLE. On that same edge Busy becomes 0.
- Frame length: Busy stays high for exactly (10 + PAR_EN)·P cycles.
- Back-to-back frames: the earliest next acceptance is the first edge where state=IDLE, i.e. the cycle in which Busy is first seen low. A DATA_VALID held continuously therefore produces frames separated by exactly one idle-high cycle.
- TX_OUT always reflects the current state. It is registered, with no combinational path from any input.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP) as a 3-bit encoding
  - localparams for start/stop bit levels (0/1)
  - a function parity_bit(data, typ)
- Sub-module uart_tx_bit_timer implements edge_cnt and bit_idx, and outputs bit_done and bit_idx. It is the transmit-side counterpart of the receive edge/bit counter. Inputs: CLK, RST, enable, clear, P.
- The top level holds the FSM, data/config latches and the output register.

Test Plan:
1. Reset, then P_DATA=0xA5, PAR_EN=0, prescale=8, one-cycle DATA_VALID -> TX_OUT shows 0,1,0,1,0,0,1,0,1,1, each level held 8 cycles. Busy is high for exactly 80 cycles, and TX_OUT=1 afterwards.
2. P_DATA=0xA5 (four ones), PAR_EN=1, prescale=16. With PAR_TYP=0 the parity bit = 0; with PAR_TYP=1 the parity bit = 1. Busy is high for 176 cycles.
3. DATA_VALID held high continuously, P_DATA changing 0x01→0xFF mid-frame, prescale=4 -> the first frame carries 0x01 unchanged. Exactly one idle-high cycle separates the frames, and the second frame carries the P_DATA value present on its acceptance edge.
4. Assert RST at cycle 30 of a prescale=8 frame -> on the next edge TX_OUT=1 and Busy=0. A DATA_VALID on the following cycle starts a clean frame.
5. Change prescale from 8 to 31 during DATA, and pulse DATA_VALID while Busy=1 -> the current frame keeps 8 cycles/bit and the pulse is ignored. The next accepted frame uses 31 cycles/bit.
6. prescale=0 and prescale=1 with 0x3C -> one cycle per bit and a 10-cycle Busy window in both cases.
